// File: rtl/dm_access_ctrl_if.sv
// Command / read-return / status bundle between the MPU datapath and the
// data-memory access sequencer.
//   master : datapath side (drives commands, observes read data and status)
//   slave  : sequencer side
// Signals:
//   cmd_valid/cmd_ready  command handshake
//   cmd_op               0 NOP, 1 SET_PTR, 2 LOAD, 3 STORE, 4 LOAD_INC,
//                        5 STORE_INC, 6 FILL, 7 reserved
//   cmd_imm              pointer value (SET_PTR) or fill count-minus-one (FILL)
//   cmd_data             store / fill data
//   rd_valid/rd_data     one-cycle load return; rd_data holds until next load
//   ptr, busy            current pointer, controller busy
interface dm_access_ctrl_if #(
    parameter int ADDR_W = 4,
    parameter int DATA_W = 4
);
    logic              cmd_valid;
    logic              cmd_ready;
    logic [2:0]        cmd_op;
    logic [ADDR_W-1:0] cmd_imm;
    logic [DATA_W-1:0] cmd_data;
    logic              rd_valid;
    logic [DATA_W-1:0] rd_data;
    logic [ADDR_W-1:0] ptr;
    logic              busy;

    modport master (
        output cmd_valid, cmd_op, cmd_imm, cmd_data,
        input  cmd_ready, rd_valid, rd_data, ptr, busy
    );

    modport slave (
        input  cmd_valid, cmd_op, cmd_imm, cmd_data,
        output cmd_ready, rd_valid, rd_data, ptr, busy
    );
endinterface

// File: rtl/dm_access_ctrl.sv
// Data-memory access sequencer for the 4-bit MPU. Sits directly in front of
// the 2^ADDR_W x DATA_W data RAM (RAM registers q on the rising edge and
// writes on the falling edge), owns the data-memory pointer and sequences
// load, store, pointer and block-fill commands.
// Ports:
//   clock, reset          system clock, asynchronous active-high reset
//   bus (slave)           command handshake, read return, ptr/busy status
//   ram_address/ram_data  RAM address and write data
//   ram_wren              RAM write enable, high only in write cycles
//   ram_q                 RAM registered read data
//
// state | meaning
// ------+---------------------------------------------------------------
// IDLE  | ready for a command; stores/SET_PTR complete here in one cycle
// RD1   | load address presented, RAM samples it on this edge
// RD2   | ram_q valid, captured into rd_data with a rd_valid pulse
// FILL  | block fill in progress, one write per cycle until cnt reaches 1
module dm_access_ctrl #(
    parameter int ADDR_W = 4,
    parameter int DATA_W = 4
) (
    input  logic              clock,
    input  logic              reset,
    dm_access_ctrl_if.slave   bus,
    output logic [ADDR_W-1:0] ram_address,
    output logic [DATA_W-1:0] ram_data,
    output logic              ram_wren,
    input  logic [DATA_W-1:0] ram_q
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RD1  = 2'd1,
        RD2  = 2'd2,
        FILL = 2'd3
    } state_t;

    localparam logic [2:0] OP_SET_PTR   = 3'd1;
    localparam logic [2:0] OP_LOAD      = 3'd2;
    localparam logic [2:0] OP_STORE     = 3'd3;
    localparam logic [2:0] OP_LOAD_INC  = 3'd4;
    localparam logic [2:0] OP_STORE_INC = 3'd5;
    localparam logic [2:0] OP_FILL      = 3'd6;

    localparam logic [ADDR_W-1:0] ONE = ADDR_W'(1);

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] ptr_q, ptr_d;
    logic [ADDR_W-1:0] cnt_q, cnt_d;
    logic [DATA_W-1:0] fill_data_q, fill_data_d;
    logic [ADDR_W-1:0] ram_address_q, ram_address_d;
    logic [DATA_W-1:0] ram_data_q, ram_data_d;
    logic              ram_wren_q, ram_wren_d;
    logic [DATA_W-1:0] rd_data_q, rd_data_d;
    logic              rd_valid_q, rd_valid_d;
    logic              accept;

    assign accept = bus.cmd_valid && (state_q == IDLE);

    always_comb begin
        state_d       = state_q;
        ptr_d         = ptr_q;
        cnt_d         = cnt_q;
        fill_data_d   = fill_data_q;
        ram_address_d = ram_address_q;
        ram_data_d    = ram_data_q;
        ram_wren_d    = 1'b0;
        rd_data_d     = rd_data_q;
        rd_valid_d    = 1'b0;

        case (state_q)
            IDLE: begin
                if (accept) begin
                    case (bus.cmd_op)
                        OP_SET_PTR: begin
                            ptr_d = bus.cmd_imm;
                        end
                        OP_STORE, OP_STORE_INC: begin
                            ram_address_d = ptr_q;
                            ram_data_d    = bus.cmd_data;
                            ram_wren_d    = 1'b1;
                            if (bus.cmd_op == OP_STORE_INC) begin
                                ptr_d = ptr_q + ONE;
                            end
                        end
                        OP_LOAD, OP_LOAD_INC: begin
                            ram_address_d = ptr_q;
                            if (bus.cmd_op == OP_LOAD_INC) begin
                                ptr_d = ptr_q + ONE;
                            end
                            state_d = RD1;
                        end
                        OP_FILL: begin
                            // First write issues on the accept edge, so a
                            // count of zero is a single write with no FILL visit.
                            cnt_d         = bus.cmd_imm;
                            fill_data_d   = bus.cmd_data;
                            ram_address_d = ptr_q;
                            ram_data_d    = bus.cmd_data;
                            ram_wren_d    = 1'b1;
                            ptr_d         = ptr_q + ONE;
                            if (bus.cmd_imm != '0) begin
                                state_d = FILL;
                            end
                        end
                        default: begin
                            // NOP and reserved opcode: accepted, no effect.
                        end
                    endcase
                end
            end
            RD1: begin
                state_d = RD2;
            end
            RD2: begin
                rd_data_d  = ram_q;
                rd_valid_d = 1'b1;
                state_d    = IDLE;
            end
            FILL: begin
                ram_address_d = ptr_q;
                ram_data_d    = fill_data_q;
                ram_wren_d    = 1'b1;
                ptr_d         = ptr_q + ONE;
                cnt_d         = cnt_q - ONE;
                if (cnt_q == ONE) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q       <= IDLE;
            ptr_q         <= '0;
            cnt_q         <= '0;
            fill_data_q   <= '0;
            ram_address_q <= '0;
            ram_data_q    <= '0;
            ram_wren_q    <= 1'b0;
            rd_data_q     <= '0;
            rd_valid_q    <= 1'b0;
        end else begin
            state_q       <= state_d;
            ptr_q         <= ptr_d;
            cnt_q         <= cnt_d;
            fill_data_q   <= fill_data_d;
            ram_address_q <= ram_address_d;
            ram_data_q    <= ram_data_d;
            ram_wren_q    <= ram_wren_d;
            rd_data_q     <= rd_data_d;
            rd_valid_q    <= rd_valid_d;
        end
    end

    // Ready and busy decode straight from the state register.
    assign bus.cmd_ready = (state_q == IDLE);
    assign bus.busy      = (state_q != IDLE);
    assign bus.ptr       = ptr_q;
    assign bus.rd_data   = rd_data_q;
    assign bus.rd_valid  = rd_valid_q;
    assign ram_address   = ram_address_q;
    assign ram_data      = ram_data_q;
    assign ram_wren      = ram_wren_q;

endmodule

// File: tb/tb_dm_access_ctrl.sv
// Scoreboard bench for dm_access_ctrl: directed commands push the expected
// RAM writes and load returns into queues; a negedge monitor pops and checks
// them whenever ram_wren or rd_valid is seen.
module tb_dm_access_ctrl;
    localparam logic [2:0] NOP = 3'd0, SET_PTR = 3'd1, LOAD = 3'd2, STORE = 3'd3;
    localparam logic [2:0] LOAD_INC = 3'd4, STORE_INC = 3'd5, FILL = 3'd6, RSVD = 3'd7;

    logic       clock = 1'b0;
    logic       reset;
    logic [3:0] ram_address, ram_data, ram_q;
    logic       ram_wren;

    always #5 clock = ~clock;

    dm_access_ctrl_if #(.ADDR_W(4), .DATA_W(4)) bus ();

    dm_access_ctrl #(.ADDR_W(4), .DATA_W(4)) dut (
        .clock       (clock),
        .reset       (reset),
        .bus         (bus),
        .ram_address (ram_address),
        .ram_data    (ram_data),
        .ram_wren    (ram_wren),
        .ram_q       (ram_q)
    );

    // RAM model: power-up contents mem[a] = 15 - a.
    logic [3:0] mem [16] = '{4'd15, 4'd14, 4'd13, 4'd12, 4'd11, 4'd10, 4'd9, 4'd8,
                             4'd7, 4'd6, 4'd5, 4'd4, 4'd3, 4'd2, 4'd1, 4'd0};
    always @(posedge clock) ram_q <= mem[ram_address];
    always @(negedge clock) if (ram_wren) mem[ram_address] <= ram_data;

    int checks = 0;
    int failures = 0;
    logic [7:0] exp_wr_q[$];
    logic [3:0] exp_rd_q[$];
    logic [7:0] mon_wr;
    logic [3:0] mon_rd;

    task automatic check(input string name, input int got, input int exp);
        checks++;
        if (got != exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", name, got, exp);
        end
    endtask

    // Monitor: every write and every load return must match the next
    // expected entry; anything unexpected is a failure.
    always @(negedge clock) begin
        if (!reset) begin
            if (ram_wren) begin
                if (exp_wr_q.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL wr_unexpected got=%0h:%0h exp=none", ram_address, ram_data);
                end else begin
                    mon_wr = exp_wr_q.pop_front();
                    check("wr_addr", ram_address, mon_wr[7:4]);
                    check("wr_data", ram_data, mon_wr[3:0]);
                end
            end
            if (bus.rd_valid) begin
                if (exp_rd_q.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL rd_unexpected got=%0h exp=none", bus.rd_data);
                end else begin
                    mon_rd = exp_rd_q.pop_front();
                    check("rd_data", bus.rd_data, mon_rd);
                end
            end
        end
    end

    // Called at a negedge; returns at the negedge after the accept edge.
    // Inputs are scrambled after acceptance to show they are sampled once.
    task automatic send(input logic [2:0] op, input logic [3:0] imm,
                        input logic [3:0] data, output int waited);
        int n = 0;
        bus.cmd_valid = 1'b1;
        bus.cmd_op    = op;
        bus.cmd_imm   = imm;
        bus.cmd_data  = data;
        while (!bus.cmd_ready && n < 50) begin
            @(negedge clock);
            n++;
        end
        if (n >= 50) begin
            checks++;
            failures++;
            $display("FAIL accept_timeout got=not_ready exp=ready");
        end
        @(posedge clock);
        @(negedge clock);
        bus.cmd_valid = 1'b0;
        bus.cmd_op    = NOP;
        bus.cmd_imm   = ~imm;
        bus.cmd_data  = ~data;
        waited = n;
    endtask

    task automatic go(input logic [2:0] op, input logic [3:0] imm, input logic [3:0] data);
        int w;
        send(op, imm, data, w);
    endtask

    task automatic push_wr(input logic [3:0] a, input logic [3:0] d);
        exp_wr_q.push_back({a, d});
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog got=running exp=finished");
        $fatal(1, "watchdog");
    end

    initial begin
        int w;
        int b;
        reset         = 1'b1;
        bus.cmd_valid = 1'b0;
        bus.cmd_op    = NOP;
        bus.cmd_imm   = '0;
        bus.cmd_data  = '0;
        repeat (2) @(negedge clock);
        reset = 1'b0;

        // Reset values
        check("rst_ptr", bus.ptr, 0);
        check("rst_ready", bus.cmd_ready, 1);
        check("rst_busy", bus.busy, 0);
        check("rst_wren", ram_wren, 0);
        check("rst_rd_valid", bus.rd_valid, 0);
        check("rst_rd_data", bus.rd_data, 0);
        check("rst_ram_addr", ram_address, 0);
        check("rst_ram_data", ram_data, 0);

        // LOAD at ptr 0: latency and ready profile
        exp_rd_q.push_back(4'hF);
        go(LOAD, 4'd0, 4'd0);
        check("load_ready_c1", bus.cmd_ready, 0);
        check("load_busy_c1", bus.busy, 1);
        @(negedge clock);
        check("load_ready_c2", bus.cmd_ready, 0);
        check("load_rdv_c2", bus.rd_valid, 0);
        @(negedge clock);
        check("load_rdv_c3", bus.rd_valid, 1);
        check("load_ready_c3", bus.cmd_ready, 1);
        check("load_ptr", bus.ptr, 0);
        @(negedge clock);
        check("load_rdv_c4", bus.rd_valid, 0);

        // Back-to-back STORE_INC across the pointer wrap
        go(SET_PTR, 4'd14, 4'd0);
        push_wr(4'd14, 4'd3);
        go(STORE_INC, 4'd0, 4'd3);
        push_wr(4'd15, 4'd5);
        go(STORE_INC, 4'd0, 4'd5);
        push_wr(4'd0, 4'd9);
        go(STORE_INC, 4'd0, 4'd9);
        check("store_inc_ptr", bus.ptr, 1);
        go(SET_PTR, 4'd15, 4'd0);
        exp_rd_q.push_back(4'd5);
        go(LOAD_INC, 4'd0, 4'd0);
        check("load_inc_wrap_ptr", bus.ptr, 0);
        repeat (2) @(negedge clock);

        // Store then load on the next cycle
        go(SET_PTR, 4'd6, 4'd0);
        push_wr(4'd6, 4'hA);
        go(STORE, 4'd0, 4'hA);
        exp_rd_q.push_back(4'hA);
        go(LOAD, 4'd0, 4'd0);
        repeat (2) @(negedge clock);

        // FILL of 6 words wrapping from 12 to 1
        go(SET_PTR, 4'd12, 4'd0);
        for (int i = 0; i < 6; i++) push_wr(4'(12 + i), 4'd7);
        go(FILL, 4'd5, 4'd7);
        b = 0;
        while (bus.busy && b < 20) begin
            check("fill_wren_run", ram_wren, 1);
            b++;
            @(negedge clock);
        end
        check("fill_busy_cycles", b, 5);
        check("fill_last_wren", ram_wren, 1);
        check("fill_ptr", bus.ptr, 2);
        @(negedge clock);
        check("fill_wren_off", ram_wren, 0);
        exp_rd_q.push_back(4'hD);
        go(LOAD, 4'd0, 4'd0);
        repeat (2) @(negedge clock);
        go(SET_PTR, 4'd0, 4'd0);
        exp_rd_q.push_back(4'd7);
        go(LOAD, 4'd0, 4'd0);
        repeat (2) @(negedge clock);

        // Reset mid-load: no rd_valid may follow
        go(LOAD, 4'd0, 4'd0);
        reset = 1'b1;
        #1;
        check("rstload_ready", bus.cmd_ready, 1);
        check("rstload_rdv", bus.rd_valid, 0);
        @(negedge clock);
        reset = 1'b0;
        repeat (3) @(negedge clock);

        // Reset during the third FILL write cycle
        go(SET_PTR, 4'd8, 4'd0);
        push_wr(4'd8, 4'd2);
        push_wr(4'd9, 4'd2);
        go(FILL, 4'd5, 4'd2);
        @(negedge clock);
        @(posedge clock);
        #1;
        check("rstfill_wren_before", ram_wren, 1);
        reset = 1'b1;
        #1;
        check("rstfill_wren", ram_wren, 0);
        check("rstfill_ptr", bus.ptr, 0);
        check("rstfill_ready", bus.cmd_ready, 1);
        check("rstfill_busy", bus.busy, 0);
        @(negedge clock);
        reset = 1'b0;
        go(SET_PTR, 4'd8, 4'd0);
        exp_rd_q.push_back(4'd2);
        exp_rd_q.push_back(4'd2);
        exp_rd_q.push_back(4'd5);
        go(LOAD_INC, 4'd0, 4'd0);
        go(LOAD_INC, 4'd0, 4'd0);
        go(LOAD_INC, 4'd0, 4'd0);
        check("rstfill_readback_ptr", bus.ptr, 11);
        repeat (3) @(negedge clock);

        // LOAD held during FILL, then reserved op and NOP
        go(SET_PTR, 4'd0, 4'd0);
        push_wr(4'd0, 4'd6);
        push_wr(4'd1, 4'd6);
        push_wr(4'd2, 4'd6);
        go(FILL, 4'd2, 4'd6);
        exp_rd_q.push_back(4'hC);
        send(LOAD, 4'd0, 4'd0, w);
        check("held_load_wait", w, 2);
        check("held_load_ptr", bus.ptr, 3);
        repeat (2) @(negedge clock);
        go(RSVD, 4'd9, 4'hF);
        go(NOP, 4'd9, 4'hF);
        repeat (3) @(negedge clock);
        check("rsvd_ptr", bus.ptr, 3);
        check("rsvd_ready", bus.cmd_ready, 1);

        // Full-array fill returns the pointer to its start
        go(SET_PTR, 4'd5, 4'd0);
        for (int i = 0; i < 16; i++) push_wr(4'(5 + i), 4'd1);
        go(FILL, 4'd15, 4'd1);
        b = 0;
        while (bus.busy && b < 40) begin
            b++;
            @(negedge clock);
        end
        check("full_fill_busy", b, 15);
        check("full_fill_ptr", bus.ptr, 5);
        exp_rd_q.push_back(4'd1);
        go(LOAD, 4'd0, 4'd0);
        repeat (4) @(negedge clock);

        check("wr_queue_empty", exp_wr_q.size(), 0);
        check("rd_queue_empty", exp_rd_q.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
